data_send: RTL and testbench

AXI4-Stream master that generates one packet of incrementing data words per rising edge of a software/VIO trigger. It is the transmit-side counterpart of the stream receiver on the same AXIS link, and drives the loopback and bring-up tests on the board. It fully honours tready backpressure and reports completion and a running packet count.

---
 rtl/data_send.sv | 143 ++++++++++++++
 tb/tb_data_send.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_send.sv
// AXI4-Stream master: emits one packet of incrementing words per rising edge of start_send,
// honouring tready backpressure and reporting completion plus a running packet count.
module data_send #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned KEEP_W = DATA_W / 8,
   parameter int unsigned LEN_W  = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              start_send,
   input  logic [LEN_W-1:0]  pkt_len,
   input  logic [DATA_W-1:0] data_seed,
   input  logic [KEEP_W-1:0] last_keep,
   output logic              axis_tvalid,
   input  logic              axis_tready,
   output logic [DATA_W-1:0] axis_tdata,
   output logic [KEEP_W-1:0] axis_tkeep,
   output logic              axis_tlast,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  pkt_cnt
);

   typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

   state_e              state_q, state_d;
   logic                start_dly_q;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    beat_q, beat_d;
   logic [KEEP_W-1:0]   lkeep_q, lkeep_d;
   logic                tvalid_q, tvalid_d;
   logic [DATA_W-1:0]   tdata_q, tdata_d;
   logic [KEEP_W-1:0]   tkeep_q, tkeep_d;
   logic                tlast_q, tlast_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;

   logic                rise;
   logic [LEN_W-1:0]    len_eff;
   logic [KEEP_W-1:0]   lkeep_eff;
   logic [LEN_W-1:0]    next_beat;
   logic                next_final;

   assign rise       = start_send & ~start_dly_q;
   assign len_eff    = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
   assign lkeep_eff  = (last_keep == '0) ? '1 : last_keep;
   assign next_beat  = beat_q + LEN_W'(1);
   assign next_final = (next_beat == len_q - LEN_W'(1));

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      beat_d    = beat_q;
      lkeep_d   = lkeep_q;
      tvalid_d  = tvalid_q;
      tdata_d   = tdata_q;
      tkeep_d   = tkeep_q;
      tlast_d   = tlast_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      pkt_cnt_d = pkt_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (rise) begin
               len_d    = len_eff;
               lkeep_d  = lkeep_eff;
               beat_d   = '0;
               tvalid_d = 1'b1;
               tdata_d  = data_seed;
               tlast_d  = (len_eff == LEN_W'(1));
               tkeep_d  = (len_eff == LEN_W'(1)) ? lkeep_eff : '1;
               busy_d   = 1'b1;
               state_d  = StSend;
            end
         end
         StSend: begin
            if (tvalid_q && axis_tready) begin
               if (tlast_q) begin
                  tvalid_d  = 1'b0;
                  tdata_d   = '0;
                  tkeep_d   = '0;
                  tlast_d   = 1'b0;
                  done_d    = 1'b1;
                  pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                  state_d   = StDone;
               end else begin
                  beat_d  = next_beat;
                  tdata_d = tdata_q + DATA_W'(1);
                  tlast_d = next_final;
                  tkeep_d = next_final ? lkeep_q : '1;
               end
            end
         end
         StDone: begin
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q     <= StIdle;
         // Held high so a trigger already asserted across reset release is not a new edge.
         start_dly_q <= 1'b1;
         len_q       <= '0;
         beat_q      <= '0;
         lkeep_q     <= '0;
         tvalid_q    <= 1'b0;
         tdata_q     <= '0;
         tkeep_q     <= '0;
         tlast_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pkt_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         start_dly_q <= start_send;
         len_q       <= len_d;
         beat_q      <= beat_d;
         lkeep_q     <= lkeep_d;
         tvalid_q    <= tvalid_d;
         tdata_q     <= tdata_d;
         tkeep_q     <= tkeep_d;
         tlast_q     <= tlast_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pkt_cnt_q   <= pkt_cnt_d;
      end
   end

   assign axis_tvalid = tvalid_q;
   assign axis_tdata  = tdata_q;
   assign axis_tkeep  = tkeep_q;
   assign axis_tlast  = tlast_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign pkt_cnt     = pkt_cnt_q;

endmodule

// File: tb/tb_data_send.sv
// Scoreboard bench for data_send: stimulus pushes modelled beats, a negedge monitor pops and
// compares every handshake, stall stability, done pulses and the packet count.
module tb_data_send;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        start_send;
   logic [7:0]  pkt_len;
   logic [31:0] data_seed;
   logic [3:0]  last_keep;
   logic        axis_tvalid;
   logic        axis_tready;
   logic [31:0] axis_tdata;
   logic [3:0]  axis_tkeep;
   logic        axis_tlast;
   logic        busy;
   logic        done;
   logic [15:0] pkt_cnt;

   data_send dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .start_send  (start_send),
      .pkt_len     (pkt_len),
      .data_seed   (data_seed),
      .last_keep   (last_keep),
      .axis_tvalid (axis_tvalid),
      .axis_tready (axis_tready),
      .axis_tdata  (axis_tdata),
      .axis_tkeep  (axis_tkeep),
      .axis_tlast  (axis_tlast),
      .busy        (busy),
      .done        (done),
      .pkt_cnt     (pkt_cnt)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } beat_t;

   beat_t       exp_q[$];
   logic [15:0] cnt_q[$];
   logic [15:0] model_cnt;
   int          vectors = 0;
   int          miscompares = 0;
   int          rdy_mode = 0;
   int          stall = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Sink readiness: always ready, toggling with occasional 5-cycle stalls, or random.
   always begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
         0: axis_tready = 1'b1;
         1: begin
            if (stall > 0) begin
               axis_tready = 1'b0;
               stall--;
            end else if ($urandom_range(0, 19) == 0) begin
               axis_tready = 1'b0;
               stall = 4;
            end else begin
               axis_tready = ~axis_tready;
            end
         end
         default: axis_tready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor
   logic        prev_stall = 1'b0;
   logic        after_last = 1'b0;
   logic [31:0] prev_d;
   logic [3:0]  prev_k;
   logic        prev_l;

   always @(negedge aclk) begin
      if (aresetn !== 1'b1) begin
         prev_stall = 1'b0;
         after_last = 1'b0;
      end else begin
         chk("done_pulse", 32'(done), 32'(after_last));
         if (after_last) begin
            chk("post_tvalid", 32'(axis_tvalid), 32'd0);
            chk("post_tkeep", 32'(axis_tkeep), 32'd0);
            chk("post_tlast", 32'(axis_tlast), 32'd0);
            chk("done_busy", 32'(busy), 32'd1);
            if (cnt_q.size() == 0) chk("cnt_available", 32'd0, 32'd1);
            else chk("pkt_cnt", 32'(pkt_cnt), 32'(cnt_q.pop_front()));
         end
         if (prev_stall) begin
            chk("stall_tvalid", 32'(axis_tvalid), 32'd1);
            chk("stall_tdata", axis_tdata, prev_d);
            chk("stall_tkeep", 32'(axis_tkeep), 32'(prev_k));
            chk("stall_tlast", 32'(axis_tlast), 32'(prev_l));
         end
         if (axis_tvalid && axis_tready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 32'd1, 32'd0);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               chk("tdata", axis_tdata, e.d);
               chk("tkeep", 32'(axis_tkeep), 32'(e.k));
               chk("tlast", 32'(axis_tlast), 32'(e.l));
            end
         end
         after_last = axis_tvalid && axis_tready && axis_tlast;
         prev_stall = axis_tvalid && !axis_tready;
         prev_d = axis_tdata;
         prev_k = axis_tkeep;
         prev_l = axis_tlast;
      end
   end

   // Reference: expected beats of one packet from the packet-level rules.
   task automatic model_pkt(input int len, input logic [31:0] seed, input logic [3:0] lk);
      int n;
      n = (len == 0) ? 1 : len;
      for (int i = 0; i < n; i++) begin
         beat_t b;
         b.d = seed + 32'(i);
         b.l = (i == n - 1);
         b.k = (i == n - 1) ? ((lk == 4'd0) ? 4'hF : lk) : 4'hF;
         exp_q.push_back(b);
      end
      model_cnt = model_cnt + 16'd1;
      cnt_q.push_back(model_cnt);
   endtask

   task automatic send_pkt(input int len, input logic [31:0] seed, input logic [3:0] lk,
                           input bit glitch);
      bit seen;
      @(posedge aclk);
      #1;
      pkt_len    = 8'(len);
      data_seed  = seed;
      last_keep  = lk;
      start_send = 1'b1;
      model_pkt(len, seed, lk);
      @(posedge aclk);
      #1;
      start_send = 1'b0;
      pkt_len    = 8'($urandom);
      data_seed  = $urandom;
      last_keep  = 4'($urandom);
      @(negedge aclk);
      chk("start_latency_tvalid", 32'(axis_tvalid), 32'd1);
      chk("start_busy", 32'(busy), 32'd1);
      if (glitch) begin
         @(posedge aclk);
         #1 start_send = 1'b0;
         @(posedge aclk);
         #1 start_send = 1'b1;
         @(posedge aclk);
         #1 start_send = 1'b0;
      end
      seen = 1'b0;
      for (int c = 0; c < 3000 && !seen; c++) begin
         @(negedge aclk);
         if (done) seen = 1'b1;
      end
      chk("done_seen", 32'(seen), 32'd1);
      @(negedge aclk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_tvalid"}, 32'(axis_tvalid), 32'd0);
      chk({tag, "_tdata"}, axis_tdata, 32'd0);
      chk({tag, "_tkeep"}, 32'(axis_tkeep), 32'd0);
      chk({tag, "_tlast"}, 32'(axis_tlast), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'd0);
   endtask

   initial begin
      aresetn     = 1'b0;
      start_send  = 1'b0;
      pkt_len     = 8'd0;
      data_seed   = 32'd0;
      last_keep   = 4'd0;
      axis_tready = 1'b1;
      model_cnt   = 16'd0;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      chk_reset_outputs("reset");
      @(posedge aclk);
      #1 aresetn = 1'b1;
      repeat (2) @(posedge aclk);

      rdy_mode = 0;
      send_pkt(11, 32'h0000_0100, 4'd0, 1'b0);
      rdy_mode = 1;
      send_pkt(11, 32'h0000_0100, 4'd0, 1'b0);
      rdy_mode = 0;
      send_pkt(0, 32'hFFFF_FFFF, 4'b0011, 1'b0);
      send_pkt(3, 32'hFFFF_FFFE, 4'd0, 1'b0);
      send_pkt(11, 32'h0000_0200, 4'd0, 1'b1);

      rdy_mode = 2;
      for (int p = 0; p < 12; p++) begin
         send_pkt(($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 24)), $urandom,
                  4'($urandom_range(0, 15)), 1'b0);
      end
      send_pkt(255, $urandom, 4'b1000, 1'b0);

      // Reset during beat 4 of an 11-beat packet with the trigger held high.
      rdy_mode = 0;
      @(posedge aclk);
      #1;
      pkt_len    = 8'd11;
      data_seed  = 32'h0000_0300;
      last_keep  = 4'd0;
      start_send = 1'b1;
      model_pkt(11, 32'h0000_0300, 4'd0);
      repeat (5) @(posedge aclk);
      #1 aresetn = 1'b0;
      @(posedge aclk);
      #1;
      exp_q.delete();
      cnt_q.delete();
      model_cnt = 16'd0;
      @(negedge aclk);
      chk_reset_outputs("midreset");
      @(posedge aclk);
      #1 aresetn = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge aclk);
         chk("held_start_tvalid", 32'(axis_tvalid), 32'd0);
         chk("held_start_busy", 32'(busy), 32'd0);
      end
      @(posedge aclk);
      #1 start_send = 1'b0;
      send_pkt(5, 32'h1234_5678, 4'b0001, 1'b0);

      repeat (4) @(posedge aclk);
      @(negedge aclk);
      chk("leftover_beats", 32'(exp_q.size()), 32'd0);
      chk("leftover_counts", 32'(cnt_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
